// File: rtl/switch_traffic_stats.sv
// Per-port drop/accept/delivery counters and in-flight tracking for the N-port switch,
// with a snapshot bank and registered read port. Define STATS_WATERMARK_EN for the in-flight high-water mark.
module switch_traffic_stats #(
  parameter int N_PORTS   = 4,
  parameter int CNT_WIDTH = 16,
  parameter int PORT_AW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORTS-1:0]           valid_in,
  input  logic [N_PORTS*N_PORTS-1:0]   target_in,
  input  logic [N_PORTS-1:0]           fifo_full,
  input  logic [N_PORTS-1:0]           valid_out,
  input  logic                         clr,
  input  logic                         snap,
  input  logic                         rd_en,
  input  logic [PORT_AW+1:0]           rd_addr,
  output logic [CNT_WIDTH-1:0]         rd_data,
  output logic                         rd_valid,
  output logic                         err
);

  localparam int IW      = CNT_WIDTH + PORT_AW + 2;
  localparam int WW      = PORT_AW + 1;
  localparam int N_SLOTS = 1 << PORT_AW;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [WW-1:0] popcnt(input logic [N_PORTS-1:0] v);
    logic [WW-1:0] c;
    c = '0;
    for (int b = 0; b < N_PORTS; b++) c = c + WW'(v[b]);
    return c;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [WW-1:0]        inc);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + (CNT_WIDTH+1)'(inc);
    return s[CNT_WIDTH] ? CNT_MAX : s[CNT_WIDTH-1:0];
  endfunction

  logic [N_PORTS-1:0][WW-1:0]        w;
  logic [N_PORTS-1:0][CNT_WIDTH-1:0] drop_reg, acc_reg, dlv_reg;
  logic [N_PORTS-1:0][CNT_WIDTH-1:0] drop_next, acc_next, dlv_next;
  logic [N_PORTS-1:0][CNT_WIDTH-1:0] drop_shd_reg, acc_shd_reg, dlv_shd_reg;
  logic [CNT_WIDTH-1:0]              infl_reg, infl_next, infl_shd_reg;
  logic                              err_reg, err_next, err_shd_reg;
  logic [CNT_WIDTH-1:0]              wm_shd_val;
  logic [IW-1:0]                     acc_sum, dlv_sum, infl_wide;
  logic                              infl_under, infl_over;
  logic [CNT_WIDTH-1:0]              rd_data_reg, rd_mux;
  logic                              rd_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_weight
      assign w[gi] = popcnt(target_in[gi*N_PORTS +: N_PORTS]);
    end
  endgenerate

  always_comb begin
    drop_next = drop_reg;
    acc_next  = acc_reg;
    dlv_next  = dlv_reg;
    acc_sum   = '0;
    dlv_sum   = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (valid_in[p]) begin
        if (fifo_full[p]) begin
          drop_next[p] = sat_add(drop_reg[p], w[p]);
        end else begin
          acc_next[p] = sat_add(acc_reg[p], w[p]);
          acc_sum     = acc_sum + IW'(w[p]);
        end
      end
      if (valid_out[p]) begin
        dlv_next[p] = sat_add(dlv_reg[p], WW'(1));
        dlv_sum     = dlv_sum + IW'(1);
      end
    end
    // Wide enough that the sign bit cleanly flags underflow.
    infl_wide  = IW'(infl_reg) + acc_sum - dlv_sum;
    infl_under = infl_wide[IW-1];
    infl_over  = !infl_wide[IW-1] && (infl_wide[IW-2:0] > (IW-1)'(CNT_MAX));
    if (infl_under)     infl_next = '0;
    else if (infl_over) infl_next = CNT_MAX;
    else                infl_next = infl_wide[CNT_WIDTH-1:0];
    err_next = err_reg | infl_under | infl_over;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_reg     <= '0;
      acc_reg      <= '0;
      dlv_reg      <= '0;
      infl_reg     <= '0;
      err_reg      <= 1'b0;
      drop_shd_reg <= '0;
      acc_shd_reg  <= '0;
      dlv_shd_reg  <= '0;
      infl_shd_reg <= '0;
      err_shd_reg  <= 1'b0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (clr) begin
        drop_reg <= '0;
        acc_reg  <= '0;
        dlv_reg  <= '0;
        infl_reg <= '0;
        err_reg  <= 1'b0;
      end else begin
        drop_reg <= drop_next;
        acc_reg  <= acc_next;
        dlv_reg  <= dlv_next;
        infl_reg <= infl_next;
        err_reg  <= err_next;
      end
      // Snapshot sees this cycle's updates even when clr also fires.
      if (snap) begin
        drop_shd_reg <= drop_next;
        acc_shd_reg  <= acc_next;
        dlv_shd_reg  <= dlv_next;
        infl_shd_reg <= infl_next;
        err_shd_reg  <= err_next;
      end
      rd_valid_reg <= rd_en;
      if (rd_en) rd_data_reg <= rd_mux;
    end
  end

`ifdef STATS_WATERMARK_EN
  logic [CNT_WIDTH-1:0] wm_reg, wm_next, wm_shd_reg;

  assign wm_next = (infl_next > wm_reg) ? infl_next : wm_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wm_reg     <= '0;
      wm_shd_reg <= '0;
    end else begin
      wm_reg <= clr ? '0 : wm_next;
      if (snap) wm_shd_reg <= wm_next;
    end
  end

  assign wm_shd_val = wm_shd_reg;
`else
  assign wm_shd_val = '0;
`endif

  // Pad the shadow bank out to the full address space so unused port slots read zero.
  logic [N_SLOTS-1:0][CNT_WIDTH-1:0] drop_rd, acc_rd, dlv_rd;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_rd_slot
      if (gi < N_PORTS) begin : g_live
        assign drop_rd[gi] = drop_shd_reg[gi];
        assign acc_rd[gi]  = acc_shd_reg[gi];
        assign dlv_rd[gi]  = dlv_shd_reg[gi];
      end else begin : g_pad
        assign drop_rd[gi] = '0;
        assign acc_rd[gi]  = '0;
        assign dlv_rd[gi]  = '0;
      end
    end
  endgenerate

  logic [PORT_AW-1:0] rd_port;
  logic [1:0]         rd_type;
  logic [PORT_AW+1:0] rd_port_x;

  assign rd_port   = rd_addr[PORT_AW+1:2];
  assign rd_type   = rd_addr[1:0];
  assign rd_port_x = {2'b00, rd_port};

  always_comb begin
    rd_mux = '0;
    case (rd_type)
      2'd0: rd_mux = drop_rd[rd_port];
      2'd1: rd_mux = acc_rd[rd_port];
      2'd2: rd_mux = dlv_rd[rd_port];
      default: begin
        if (rd_port_x == (PORT_AW+2)'(0))      rd_mux = infl_shd_reg;
        else if (rd_port_x == (PORT_AW+2)'(1)) rd_mux = CNT_WIDTH'({err_shd_reg, fifo_full});
        else if (rd_port_x == (PORT_AW+2)'(2)) rd_mux = wm_shd_val;
        else                                   rd_mux = '0;
      end
    endcase
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_switch_traffic_stats.sv
// Directed bench for switch_traffic_stats (N_PORTS=4, CNT_WIDTH=16) with hand-computed expectations.
module tb_switch_traffic_stats;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid_in;
  logic [15:0] target_in;
  logic [3:0]  fifo_full;
  logic [3:0]  valid_out;
  logic        clr;
  logic        snap;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  switch_traffic_stats #(.N_PORTS(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .target_in(target_in),
    .fifo_full(fifo_full), .valid_out(valid_out), .clr(clr), .snap(snap),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input logic [3:0] vi, input logic [15:0] tgt, input logic [3:0] ff,
                      input logic [3:0] vo, input logic c, input logic s);
    valid_in = vi; target_in = tgt; fifo_full = ff; valid_out = vo; clr = c; snap = s;
    @(posedge clk); #1;
    valid_in = '0; target_in = '0; fifo_full = '0; valid_out = '0; clr = 1'b0; snap = 1'b0;
  endtask

  function automatic logic [3:0] addr(input int port, input int typ);
    logic [1:0] p;
    logic [1:0] t;
    p = port[1:0];
    t = typ[1:0];
    return {p, t};
  endfunction

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk(tag, {16'd0, rd_data}, {16'd0, exp});
  endtask

  task automatic do_snap();
    step(4'b0, 16'h0, 4'b0, 4'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; valid_in = '0; target_in = '0; fifo_full = '0; valid_out = '0;
    clr = 1'b0; snap = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_rd_data", {16'd0, rd_data}, 32'd0);

    // Port0 accepts weight 3 for 3 cycles.
    repeat (3) step(4'b0001, 16'h000E, 4'b0000, 4'b0, 1'b0, 1'b0);
    do_snap();
    rd_chk("acc0_w3x3", addr(0, 1), 16'd9);
    rd_chk("infl_9", addr(0, 3), 16'd9);
    rd_chk("drop0_zero", addr(0, 0), 16'd0);

    // Port2 drops weight 3 for 5 cycles.
    repeat (5) step(4'b0100, 16'h0B00, 4'b0100, 4'b0, 1'b0, 1'b0);
    do_snap();
    rd_chk("drop2_15", addr(2, 0), 16'd15);
    rd_chk("acc2_zero", addr(2, 1), 16'd0);
    rd_chk("infl_after_drop", addr(0, 3), 16'd9);
    fifo_full = 4'b0101;
    rd_chk("misc1_live_ff", addr(1, 3), 16'd5);
    fifo_full = 4'b0000;

    // Deliver on every port for two cycles.
    repeat (2) step(4'b0, 16'h0, 4'b0, 4'b1111, 1'b0, 1'b0);
    do_snap();
    rd_chk("infl_after_dlv", addr(0, 3), 16'd1);
    chk("rd_valid_hi", {31'd0, rd_valid}, 32'd1);
    step(4'b0, 16'h0, 4'b0, 4'b0, 1'b0, 1'b0);
    chk("rd_valid_lo", {31'd0, rd_valid}, 32'd0);
    chk("rd_data_hold", {16'd0, rd_data}, 32'd1);
    for (int k = 0; k < 4; k++) rd_chk($sformatf("dlv%0d", k), addr(k, 2), 16'd2);

    // Drain to zero, then underflow.
    step(4'b0, 16'h0, 4'b0, 4'b0001, 1'b0, 1'b0);
    chk("no_err_at_zero", {31'd0, err}, 32'd0);
    step(4'b0, 16'h0, 4'b0, 4'b0010, 1'b0, 1'b0);
    chk("err_underflow", {31'd0, err}, 32'd1);
    do_snap();
    rd_chk("infl_clamped0", addr(0, 3), 16'd0);
    rd_chk("misc1_err", addr(1, 3), 16'h0010);
    step(4'b0, 16'h0, 4'b0, 4'b0, 1'b1, 1'b0);
    chk("err_cleared", {31'd0, err}, 32'd0);
    rd_chk("shadow_kept", addr(0, 1), 16'd9);
    // Snap alongside rd_en returns the pre-snap shadow value.
    snap = 1'b1;
    rd_chk("rd_pre_snap", addr(0, 1), 16'd9);
    snap = 1'b0;
    rd_chk("acc0_cleared", addr(0, 1), 16'd0);
    rd_chk("dlv1_cleared", addr(1, 2), 16'd0);

    // Saturation: 16383*4 + 2 = 65534, then +4 saturates.
    repeat (16383) step(4'b1000, 16'hF000, 4'b0, 4'b0, 1'b0, 1'b0);
    step(4'b1000, 16'h3000, 4'b0, 4'b0, 1'b0, 1'b0);
    chk("no_err_65534", {31'd0, err}, 32'd0);
    do_snap();
    rd_chk("acc3_65534", addr(3, 1), 16'd65534);
    step(4'b1000, 16'hF000, 4'b0, 4'b0, 1'b0, 1'b0);
    chk("err_overflow", {31'd0, err}, 32'd1);
    step(4'b1000, 16'hF000, 4'b0, 4'b0, 1'b0, 1'b1);
    rd_chk("acc3_sat", addr(3, 1), 16'hFFFF);
    rd_chk("infl_sat", addr(0, 3), 16'hFFFF);

    // clr + snap + accept in one cycle.
    step(4'b0, 16'h0, 4'b0, 4'b0, 1'b1, 1'b0);
    step(4'b0001, 16'h0003, 4'b0, 4'b0, 1'b0, 1'b0);
    step(4'b0001, 16'h0003, 4'b0, 4'b0, 1'b1, 1'b1);
    rd_chk("shadow_acc_prev_plus2", addr(0, 1), 16'd4);
    do_snap();
    rd_chk("live_acc_cleared", addr(0, 1), 16'd0);

    // Peak in-flight 12, then drain.
    repeat (3) step(4'b0001, 16'h000F, 4'b0, 4'b0, 1'b0, 1'b0);
    repeat (3) step(4'b0, 16'h0, 4'b0, 4'b1111, 1'b0, 1'b0);
    do_snap();
    rd_chk("infl_drained", addr(0, 3), 16'd0);
`ifdef STATS_WATERMARK_EN
    rd_chk("watermark", addr(2, 3), 16'd12);
`else
    rd_chk("watermark_off", addr(2, 3), 16'd0);
`endif
    rd_chk("misc3_zero", addr(3, 3), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
